// File: rtl/drw_axi_wburst.sv
// AXI write-burst engine: packs address+data runs into 4 KB-safe INCR bursts, store-and-forward.
// Optional DRW_WBURST_PERF_EN adds the BURST_CNT AW-handshake counter.
module drw_axi_wburst #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST          = 16,
  parameter int FIFO_DEPTH         = 64,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                              CLK,
  input  logic                              ARST,
  input  logic                              RSTS,
  input  logic                              WADDRVLD,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     WADDR,
  input  logic                              WDATAVLD,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     WDATA_IN,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   WSTRB_IN,
  input  logic                              WLAST_IN,
  output logic                              IN_WREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     AWADDR,
  output logic [7:0]                        AWLEN,
  output logic                              AWVALID,
  input  logic                              AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  output logic                              WLAST,
  output logic                              WVALID,
  input  logic                              WREADY,
  input  logic [1:0]                        BRESP,
  input  logic                              BVALID,
  output logic                              BREADY,
  output logic                              BUSY,
  output logic                              ERR,
  output logic [31:0]                       BURST_CNT
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DW + BYTES;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;

  logic rst;
  assign rst = ARST | RSTS;

  logic          run_open;
  logic [AW-1:0] cur_addr;
  logic [CW-1:0] beat_cnt;
  logic [CW:0]   cnt_p1;
  logic [11:0]   end_lo;
  logic          in_fire, close_c;

  logic [EW-1:0] dmem [FIFO_DEPTH];
  logic [PW-1:0] dwp, drp;
  logic [PW:0]   dcnt;
  logic          d_full, d_empty;

  logic [AW-1:0] bq_addr [4];
  logic [7:0]    bq_len  [4];
  logic [1:0]    bq_wp, bq_rp;
  logic [2:0]    bq_cnt;
  logic          bq_full;

  logic [1:0]    state;
  logic [AW-1:0] awaddr_r;
  logic [7:0]    awlen_r;
  logic [7:0]    wleft;
  logic [3:0]    osd;
  logic          bready_r, err_r;
  logic          aw_fire, w_fire, b_fire;

  // ---------------- assembler ----------------
  assign d_full    = (dcnt == (PW+1)'(FIFO_DEPTH));
  assign d_empty   = (dcnt == '0);
  assign bq_full   = (bq_cnt == 3'd4);
  assign IN_WREADY = run_open & ~d_full & ~bq_full;
  assign in_fire   = WDATAVLD & IN_WREADY;
  assign cnt_p1    = {1'b0, beat_cnt} + 1'b1;
  // Byte address just past this beat; landing on 4 KB means the burst must end here.
  assign end_lo    = cur_addr[11:0] + (12'(cnt_p1) << BSH);
  assign close_c   = WLAST_IN | (cnt_p1 == (CW+1)'(MAX_BURST)) | (end_lo == 12'd0);

  always_ff @(posedge CLK) begin
    if (rst) begin
      run_open <= 1'b0;
      cur_addr <= '0;
      beat_cnt <= '0;
    end else if (!run_open) begin
      if (WADDRVLD) begin
        cur_addr <= WADDR;
        beat_cnt <= '0;
        run_open <= 1'b1;
      end
    end else if (in_fire) begin
      if (close_c) begin
        cur_addr <= cur_addr + (AW'(cnt_p1) << BSH);
        beat_cnt <= '0;
        if (WLAST_IN) run_open <= 1'b0;
      end else begin
        beat_cnt <= cnt_p1[CW-1:0];
      end
    end
  end

  // ---------------- data FIFO ----------------
  always_ff @(posedge CLK) begin
    if (in_fire) dmem[dwp] <= {WSTRB_IN, WDATA_IN};
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      dwp  <= '0;
      drp  <= '0;
      dcnt <= '0;
    end else begin
      if (in_fire) dwp <= dwp + 1'b1;
      if (w_fire)  drp <= drp + 1'b1;
      case ({in_fire, w_fire})
        2'b10:   dcnt <= dcnt + 1'b1;
        2'b01:   dcnt <= dcnt - 1'b1;
        default: dcnt <= dcnt;
      endcase
    end
  end

  // ---------------- burst queue ----------------
  always_ff @(posedge CLK) begin
    if (in_fire && close_c) begin
      bq_addr[bq_wp] <= cur_addr;
      bq_len[bq_wp]  <= 8'(beat_cnt);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      bq_wp  <= '0;
      bq_rp  <= '0;
      bq_cnt <= '0;
    end else begin
      if (in_fire && close_c) bq_wp <= bq_wp + 1'b1;
      if (aw_fire)            bq_rp <= bq_rp + 1'b1;
      case ({in_fire & close_c, aw_fire})
        2'b10:   bq_cnt <= bq_cnt + 1'b1;
        2'b01:   bq_cnt <= bq_cnt - 1'b1;
        default: bq_cnt <= bq_cnt;
      endcase
    end
  end

  // ---------------- issue FSM ----------------
  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  assign b_fire  = BVALID & BREADY;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= S_IDLE;
      awaddr_r <= '0;
      awlen_r  <= '0;
      wleft    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bq_cnt != 3'd0 && osd < 4'(MAX_OUTSTANDING)) begin
          awaddr_r <= bq_addr[bq_rp];
          awlen_r  <= bq_len[bq_rp];
          state    <= S_AW;
        end
        S_AW: if (AWREADY) begin
          wleft <= awlen_r;
          state <= S_W;
        end
        S_W: if (w_fire) begin
          if (wleft == 8'd0) state <= S_IDLE;
          else               wleft <= wleft - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign AWVALID = (state == S_AW);
  assign AWADDR  = awaddr_r;
  assign AWLEN   = awlen_r;
  // The whole burst is already in the FIFO, so the empty guard never stalls a legal burst.
  assign WVALID  = (state == S_W) & ~d_empty;
  assign WLAST   = WVALID & (wleft == 8'd0);
  assign {WSTRB, WDATA} = WVALID ? dmem[drp] : '0;

  // ---------------- B channel ----------------
  always_ff @(posedge CLK) begin
    if (rst) begin
      osd      <= '0;
      bready_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      bready_r <= 1'b1;
      if (b_fire && BRESP != 2'b00) err_r <= 1'b1;
      case ({aw_fire, b_fire})
        2'b10:   osd <= osd + 1'b1;
        2'b01:   if (osd != 4'd0) osd <= osd - 1'b1;
        default: osd <= osd;
      endcase
    end
  end

  assign BREADY = bready_r;
  assign ERR    = err_r;
  assign BUSY   = run_open | ~d_empty | (osd != 4'd0);

`ifdef DRW_WBURST_PERF_EN
  logic [31:0] burst_cnt_r;
  always_ff @(posedge CLK) begin
    if (rst)          burst_cnt_r <= '0;
    else if (aw_fire) burst_cnt_r <= burst_cnt_r + 1'b1;
  end
  assign BURST_CNT = burst_cnt_r;
`else
  assign BURST_CNT = '0;
`endif

endmodule
